hazard_forward_scoreboard: RTL and testbench

//  Parametrised forwarding/hazard unit for the pipelined CPU. It tracks in-flight destination

---
 rtl/hazard_forward_scoreboard_pkg.sv | 11 +
 rtl/hazard_forward_scoreboard_fwd_operand_sel.sv | 45 ++++
 rtl/hazard_forward_scoreboard.sv | 141 ++++++++++++++
 tb/tb_hazard_forward_scoreboard.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_forward_scoreboard_pkg.sv
// Shared encodings for the forwarding/hazard unit.
package hazard_forward_scoreboard_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_SEL_RF  = 2'b00;
  localparam fwd_sel_t FWD_SEL_EX  = 2'b01;
  localparam fwd_sel_t FWD_SEL_MEM = 2'b10;
  localparam fwd_sel_t FWD_SEL_WB  = 2'b11;

endpackage

// File: rtl/hazard_forward_scoreboard_fwd_operand_sel.sv
// Priority compare and mux for one ID operand: youngest in-flight producer wins.
module hazard_forward_scoreboard_fwd_operand_sel
  import hazard_forward_scoreboard_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned REG_AW    = 2
) (
  input  logic                 used,
  input  logic [REG_AW-1:0]    src_reg,
  input  logic [WORD_SIZE-1:0] rf_data,
  input  logic                 ex_valid,
  input  logic [REG_AW-1:0]    ex_reg,
  input  logic                 ex_is_load,
  input  logic                 mem_valid,
  input  logic [REG_AW-1:0]    mem_reg,
  input  logic                 mem_is_load,
  input  logic                 wb_valid,
  input  logic [REG_AW-1:0]    wb_reg,
  input  logic [WORD_SIZE-1:0] ex_alu_out,
  input  logic [WORD_SIZE-1:0] mem_alu_out,
  input  logic [WORD_SIZE-1:0] mem_read_data,
  input  logic [WORD_SIZE-1:0] wb_data,
  output fwd_sel_t             sel,
  output logic [WORD_SIZE-1:0] data
);

  always_comb begin
    sel  = FWD_SEL_RF;
    data = rf_data;
    if (used) begin
      // A load in EX has no data yet; the stall logic covers that case.
      if (ex_valid && (ex_reg == src_reg) && !ex_is_load) begin
        sel  = FWD_SEL_EX;
        data = ex_alu_out;
      end else if (mem_valid && (mem_reg == src_reg)) begin
        sel  = FWD_SEL_MEM;
        data = mem_is_load ? mem_read_data : mem_alu_out;
      end else if (wb_valid && (wb_reg == src_reg)) begin
        sel  = FWD_SEL_WB;
        data = wb_data;
      end
    end
  end

endmodule

// File: rtl/hazard_forward_scoreboard.sv
// Forwarding/hazard unit: EX/MEM/WB destination pipeline, load-use stall, stall counter.
module hazard_forward_scoreboard
  import hazard_forward_scoreboard_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned NUM_REGS  = 4,
  parameter int unsigned REG_AW    = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 freeze,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [REG_AW-1:0]    id_rs,
  input  logic [REG_AW-1:0]    id_rt,
  input  logic                 id_rs_used,
  input  logic                 id_rt_used,
  input  logic                 id_wr_en,
  input  logic [REG_AW-1:0]    id_wr_reg,
  input  logic                 id_is_load,
  input  logic [WORD_SIZE-1:0] id_rs_data,
  input  logic [WORD_SIZE-1:0] id_rt_data,
  input  logic [WORD_SIZE-1:0] ex_alu_out,
  input  logic [WORD_SIZE-1:0] mem_alu_out,
  input  logic [WORD_SIZE-1:0] mem_read_data,
  input  logic [WORD_SIZE-1:0] wb_data,
  output logic [WORD_SIZE-1:0] fwd_rs_data,
  output logic [WORD_SIZE-1:0] fwd_rt_data,
  output fwd_sel_t             fwd_rs_sel,
  output fwd_sel_t             fwd_rt_sel,
  output logic                 stall,
  output logic [CNT_W-1:0]     stall_count
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] wr_reg;
    logic              is_load;
  } desc_t;

  desc_t            ex_q, ex_d;
  desc_t            mem_q, wb_q;
  desc_t            id_desc;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             rs_load_hit, rt_load_hit;
  logic             wr_reg_in_range;

  // Addresses past NUM_REGS name no register, so they never become producers.
  assign wr_reg_in_range = 32'(id_wr_reg) < NUM_REGS;

  always_comb begin
    id_desc         = '0;
    id_desc.valid   = id_valid && id_wr_en && wr_reg_in_range;
    id_desc.wr_reg  = id_wr_reg;
    id_desc.is_load = id_is_load;
  end

  assign rs_load_hit = id_rs_used && ex_q.valid && ex_q.is_load && (ex_q.wr_reg == id_rs);
  assign rt_load_hit = id_rt_used && ex_q.valid && ex_q.is_load && (ex_q.wr_reg == id_rt);

  // Flush kills the consumer, so a flushed instruction never waits on a load.
  assign stall = id_valid && !flush && (rs_load_hit || rt_load_hit);

  always_comb begin
    ex_d = id_desc;
    if (stall || flush || !id_valid) begin
      ex_d = '0;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      stall_count_q <= '0;
    end else if (!freeze) begin
      wb_q          <= mem_q;
      mem_q         <= ex_q;
      ex_q          <= ex_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

  hazard_forward_scoreboard_fwd_operand_sel #(
    .WORD_SIZE (WORD_SIZE),
    .REG_AW    (REG_AW)
  ) u_fwd_rs (
    .used          (id_rs_used),
    .src_reg       (id_rs),
    .rf_data       (id_rs_data),
    .ex_valid      (ex_q.valid),
    .ex_reg        (ex_q.wr_reg),
    .ex_is_load    (ex_q.is_load),
    .mem_valid     (mem_q.valid),
    .mem_reg       (mem_q.wr_reg),
    .mem_is_load   (mem_q.is_load),
    .wb_valid      (wb_q.valid),
    .wb_reg        (wb_q.wr_reg),
    .ex_alu_out    (ex_alu_out),
    .mem_alu_out   (mem_alu_out),
    .mem_read_data (mem_read_data),
    .wb_data       (wb_data),
    .sel           (fwd_rs_sel),
    .data          (fwd_rs_data)
  );

  hazard_forward_scoreboard_fwd_operand_sel #(
    .WORD_SIZE (WORD_SIZE),
    .REG_AW    (REG_AW)
  ) u_fwd_rt (
    .used          (id_rt_used),
    .src_reg       (id_rt),
    .rf_data       (id_rt_data),
    .ex_valid      (ex_q.valid),
    .ex_reg        (ex_q.wr_reg),
    .ex_is_load    (ex_q.is_load),
    .mem_valid     (mem_q.valid),
    .mem_reg       (mem_q.wr_reg),
    .mem_is_load   (mem_q.is_load),
    .wb_valid      (wb_q.valid),
    .wb_reg        (wb_q.wr_reg),
    .ex_alu_out    (ex_alu_out),
    .mem_alu_out   (mem_alu_out),
    .mem_read_data (mem_read_data),
    .wb_data       (wb_data),
    .sel           (fwd_rt_sel),
    .data          (fwd_rt_data)
  );

endmodule

// File: tb/tb_hazard_forward_scoreboard.sv
// Scenario bench for hazard_forward_scoreboard; a CNT_W=2 twin checks counter saturation.
module tb_hazard_forward_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n, freeze, flush, id_valid;
  logic [1:0]  id_rs, id_rt, id_wr_reg;
  logic        id_rs_used, id_rt_used, id_wr_en, id_is_load;
  logic [15:0] id_rs_data, id_rt_data, ex_alu_out, mem_alu_out, mem_read_data, wb_data;
  logic [15:0] fwd_rs_data, fwd_rt_data, sat_rs_data, sat_rt_data;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel, sat_rs_sel, sat_rt_sel;
  logic        stall, sat_stall;
  logic [15:0] stall_count;
  logic [1:0]  sat_count;

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst, v, fl, fr, ru, tu, we, ld, stall, ck;
    logic [1:0]  rs, rt, wr, rs_sel, rt_sel;
    logic [15:0] rs_d, rt_d;
  } step_t;

  step_t       exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_cnt = '0;
  logic [1:0]  exp_sat = '0;

  hazard_forward_scoreboard #(.WORD_SIZE(16), .NUM_REGS(4), .REG_AW(2), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_is_load(id_is_load),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .ex_alu_out(ex_alu_out),
    .mem_alu_out(mem_alu_out), .mem_read_data(mem_read_data), .wb_data(wb_data),
    .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data), .fwd_rs_sel(fwd_rs_sel),
    .fwd_rt_sel(fwd_rt_sel), .stall(stall), .stall_count(stall_count)
  );

  hazard_forward_scoreboard #(.WORD_SIZE(16), .NUM_REGS(4), .REG_AW(2), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_is_load(id_is_load),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .ex_alu_out(ex_alu_out),
    .mem_alu_out(mem_alu_out), .mem_read_data(mem_read_data), .wb_data(wb_data),
    .fwd_rs_data(sat_rs_data), .fwd_rt_data(sat_rt_data), .fwd_rs_sel(sat_rs_sel),
    .fwd_rt_sel(sat_rt_sel), .stall(sat_stall), .stall_count(sat_count)
  );

  function automatic step_t mk(string name, int rst, int v, int rs, int ru, int rt, int tu,
                               int we, int wr, int ld, int fl, int fr, int st, int ck,
                               int rs_sel, logic [15:0] rs_d, int rt_sel, logic [15:0] rt_d);
    step_t s;
    s.name = name;     s.rst = (rst != 0); s.v = (v != 0);       s.rs = 2'(rs);
    s.ru = (ru != 0);  s.rt = 2'(rt);      s.tu = (tu != 0);     s.we = (we != 0);
    s.wr = 2'(wr);     s.ld = (ld != 0);   s.fl = (fl != 0);     s.fr = (fr != 0);
    s.stall = (st != 0); s.ck = (ck != 0); s.rs_sel = 2'(rs_sel); s.rs_d = rs_d;
    s.rt_sel = 2'(rt_sel); s.rt_d = rt_d;
    return s;
  endfunction

  task automatic set_data(input logic [15:0] ex, input logic [15:0] mem, input logic [15:0] wb);
    id_rs_data = 16'hAAAA; id_rt_data = 16'h5555; mem_read_data = 16'hBEEF;
    ex_alu_out = ex; mem_alu_out = mem; wb_data = wb;
  endtask

  // Reset is asynchronous, so the counter model clears as soon as it is driven.
  task automatic drive(input step_t s);
    reset_n = s.rst; id_valid = s.v; flush = s.fl; freeze = s.fr;
    id_rs = s.rs; id_rs_used = s.ru; id_rt = s.rt; id_rt_used = s.tu;
    id_wr_en = s.we; id_wr_reg = s.wr; id_is_load = s.ld;
    if (!s.rst) begin
      exp_cnt = '0;
      exp_sat = '0;
    end
  endtask

  task automatic advance(input step_t s);
    @(posedge clk);
    if (s.rst && !s.fr && s.stall) begin
      exp_cnt = exp_cnt + 16'd1;
      if (exp_sat != 2'b11) exp_sat = exp_sat + 2'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    step_t s[$];
    step_t e;
    set_data(16'h1234, 16'h2222, 16'h3333);
    s.push_back(mk("rst_alu", 0, 1, 1,1, 2,1, 1,1,0, 0,0, 0,1, 0,16'hAAAA, 0,16'h5555));
    s.push_back(mk("rst_load", 0, 1, 1,1, 2,1, 1,1,1, 0,0, 0,1, 0,16'hAAAA, 0,16'h5555));
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(s[i]);
      @(negedge clk); e = exp_q.pop_front();
      checks++;
      if (stall !== e.stall) begin
        failures++; $display("FAIL %s stall got %b want %b", e.name, stall, e.stall);
      end
      checks++;
      if (stall_count !== exp_cnt || sat_count !== exp_sat) begin
        failures++;
        $display("FAIL %s count got %0d/%0d want %0d/%0d", e.name, stall_count, sat_count,
                 exp_cnt, exp_sat);
      end
      if (e.ck) begin
        checks++;
        if (fwd_rs_sel !== e.rs_sel || fwd_rs_data !== e.rs_d ||
            fwd_rt_sel !== e.rt_sel || fwd_rt_data !== e.rt_d) begin
          failures++;
          $display("FAIL %s fwd got rs=%0d:%h rt=%0d:%h want rs=%0d:%h rt=%0d:%h", e.name,
                   fwd_rs_sel, fwd_rs_data, fwd_rt_sel, fwd_rt_data, e.rs_sel, e.rs_d,
                   e.rt_sel, e.rt_d);
        end
      end
      advance(s[i]);
    end
  endtask

  task automatic test_ex_forward();
    step_t s[$];
    step_t e;
    set_data(16'h1234, 16'h2222, 16'h3333);
    s.push_back(mk("t1_prod", 1, 1, 0,1, 0,1, 1,1,0, 0,0, 0,1, 0,16'hAAAA, 0,16'h5555));
    s.push_back(mk("t1_ex", 1, 1, 1,1, 1,1, 1,2,0, 0,0, 0,1, 1,16'h1234, 1,16'h1234));
    s.push_back(mk("t1_mem_ex", 1, 0, 1,1, 2,1, 0,0,0, 0,0, 0,1, 2,16'h2222, 1,16'h1234));
    s.push_back(mk("t1_wb_mem", 1, 0, 1,1, 2,1, 0,0,0, 0,0, 0,1, 3,16'h3333, 2,16'h2222));
    s.push_back(mk("t1_unused", 1, 0, 1,0, 2,0, 0,0,0, 0,0, 0,1, 0,16'hAAAA, 0,16'h5555));
    s.push_back(mk("t1_drain", 1, 0, 1,1, 2,1, 0,0,0, 0,0, 0,1, 0,16'hAAAA, 0,16'h5555));
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(s[i]);
      @(negedge clk); e = exp_q.pop_front();
      checks++;
      if (stall !== e.stall) begin
        failures++; $display("FAIL %s stall got %b want %b", e.name, stall, e.stall);
      end
      if (e.ck) begin
        checks++;
        if (fwd_rs_sel !== e.rs_sel || fwd_rs_data !== e.rs_d ||
            fwd_rt_sel !== e.rt_sel || fwd_rt_data !== e.rt_d) begin
          failures++;
          $display("FAIL %s fwd got rs=%0d:%h rt=%0d:%h want rs=%0d:%h rt=%0d:%h", e.name,
                   fwd_rs_sel, fwd_rs_data, fwd_rt_sel, fwd_rt_data, e.rs_sel, e.rs_d,
                   e.rt_sel, e.rt_d);
        end
      end
      advance(s[i]);
    end
  endtask

  task automatic test_load_use();
    step_t s[$];
    step_t e;
    set_data(16'h1234, 16'h2222, 16'h3333);
    s.push_back(mk("t2_load", 1, 1, 0,1, 0,0, 1,1,1, 0,0, 0,1, 0,16'hAAAA, 0,16'h5555));
    s.push_back(mk("t2_stall", 1, 1, 1,1, 0,0, 1,3,0, 0,0, 1,0, 0,16'h0, 0,16'h0));
    s.push_back(mk("t2_mem_ld", 1, 1, 1,1, 0,0, 1,3,0, 0,0, 0,1, 2,16'hBEEF, 0,16'h5555));
    s.push_back(mk("t2_wb_ld", 1, 0, 1,1, 0,0, 0,0,0, 0,0, 0,1, 3,16'h3333, 0,16'h5555));
    s.push_back(mk("t2_drain1", 1, 0, 3,0, 3,0, 0,0,0, 0,0, 0,1, 0,16'hAAAA, 0,16'h5555));
    s.push_back(mk("t2_drain2", 1, 0, 3,0, 3,0, 0,0,0, 0,0, 0,1, 0,16'hAAAA, 0,16'h5555));
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(s[i]);
      @(negedge clk); e = exp_q.pop_front();
      checks++;
      if (stall !== e.stall) begin
        failures++; $display("FAIL %s stall got %b want %b", e.name, stall, e.stall);
      end
      checks++;
      if (stall_count !== exp_cnt) begin
        failures++; $display("FAIL %s count got %0d want %0d", e.name, stall_count, exp_cnt);
      end
      if (e.ck) begin
        checks++;
        if (fwd_rs_sel !== e.rs_sel || fwd_rs_data !== e.rs_d ||
            fwd_rt_sel !== e.rt_sel || fwd_rt_data !== e.rt_d) begin
          failures++;
          $display("FAIL %s fwd got rs=%0d:%h rt=%0d:%h want rs=%0d:%h rt=%0d:%h", e.name,
                   fwd_rs_sel, fwd_rs_data, fwd_rt_sel, fwd_rt_data, e.rs_sel, e.rs_d,
                   e.rt_sel, e.rt_d);
        end
      end
      advance(s[i]);
    end
  endtask

  task automatic test_back_to_back();
    step_t s[$];
    step_t e;
    set_data(16'h0001, 16'h0002, 16'h0003);
    for (int k = 0; k < 3; k++) begin
      s.push_back(mk("t3_write", 1, 1, 0,0, 0,0, 1,3,0, 0,0, 0,1, 0,16'hAAAA, 0,16'h5555));
    end
    s.push_back(mk("t3_ex", 1, 1, 3,1, 3,1, 0,0,0, 0,0, 0,1, 1,16'h0001, 1,16'h0001));
    s.push_back(mk("t3_mem", 1, 1, 3,1, 3,1, 0,0,0, 0,0, 0,1, 2,16'h0002, 2,16'h0002));
    s.push_back(mk("t3_wb", 1, 1, 3,1, 3,1, 0,0,0, 0,0, 0,1, 3,16'h0003, 3,16'h0003));
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(s[i]);
      @(negedge clk); e = exp_q.pop_front();
      checks++;
      if (stall !== e.stall) begin
        failures++; $display("FAIL %s stall got %b want %b", e.name, stall, e.stall);
      end
      checks++;
      if (fwd_rs_sel !== e.rs_sel || fwd_rs_data !== e.rs_d ||
          fwd_rt_sel !== e.rt_sel || fwd_rt_data !== e.rt_d) begin
        failures++;
        $display("FAIL %s fwd got rs=%0d:%h rt=%0d:%h want rs=%0d:%h rt=%0d:%h", e.name,
                 fwd_rs_sel, fwd_rs_data, fwd_rt_sel, fwd_rt_data, e.rs_sel, e.rs_d,
                 e.rt_sel, e.rt_d);
      end
      advance(s[i]);
    end
  endtask

  task automatic test_freeze();
    step_t s[$];
    step_t e;
    set_data(16'h1234, 16'h2222, 16'h3333);
    s.push_back(mk("t4_load", 1, 1, 0,1, 0,0, 1,2,1, 0,0, 0,1, 0,16'hAAAA, 0,16'h5555));
    for (int k = 0; k < 5; k++) begin
      s.push_back(mk("t4_frozen", 1, 1, 2,1, 0,0, 1,0,0, 0,1, 1,0, 0,16'h0, 0,16'h0));
    end
    s.push_back(mk("t4_release", 1, 1, 2,1, 0,0, 1,0,0, 0,0, 1,0, 0,16'h0, 0,16'h0));
    s.push_back(mk("t4_resolved", 1, 1, 2,1, 0,0, 1,0,0, 0,0, 0,1, 2,16'hBEEF, 0,16'h5555));
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(s[i]);
      @(negedge clk); e = exp_q.pop_front();
      checks++;
      if (stall !== e.stall) begin
        failures++; $display("FAIL %s stall got %b want %b", e.name, stall, e.stall);
      end
      checks++;
      if (stall_count !== exp_cnt || sat_count !== exp_sat) begin
        failures++;
        $display("FAIL %s count got %0d/%0d want %0d/%0d", e.name, stall_count, sat_count,
                 exp_cnt, exp_sat);
      end
      if (e.ck) begin
        checks++;
        if (fwd_rs_sel !== e.rs_sel || fwd_rs_data !== e.rs_d ||
            fwd_rt_sel !== e.rt_sel || fwd_rt_data !== e.rt_d) begin
          failures++;
          $display("FAIL %s fwd got rs=%0d:%h rt=%0d:%h want rs=%0d:%h rt=%0d:%h", e.name,
                   fwd_rs_sel, fwd_rs_data, fwd_rt_sel, fwd_rt_data, e.rs_sel, e.rs_d,
                   e.rt_sel, e.rt_d);
        end
      end
      advance(s[i]);
    end
  endtask

  task automatic test_flush_reset();
    step_t s[$];
    step_t e;
    set_data(16'h1234, 16'h2222, 16'h3333);
    s.push_back(mk("t5_load", 1, 1, 3,1, 0,0, 1,1,1, 0,0, 0,1, 0,16'hAAAA, 0,16'h5555));
    // The flushed consumer also writes r1: if it leaked into EX, rs would pick EX next cycle.
    s.push_back(mk("t5_flush", 1, 1, 1,1, 0,0, 1,1,0, 1,0, 0,1, 0,16'hAAAA, 0,16'h5555));
    s.push_back(mk("t5_bubble", 1, 1, 1,1, 0,0, 0,0,0, 0,0, 0,1, 2,16'hBEEF, 0,16'h5555));
    s.push_back(mk("t5_prod", 1, 1, 0,0, 0,0, 1,1,0, 0,0, 0,1, 0,16'hAAAA, 0,16'h5555));
    s.push_back(mk("t5_reset", 0, 1, 1,1, 1,1, 0,0,0, 0,0, 0,1, 0,16'hAAAA, 0,16'h5555));
    s.push_back(mk("t5_after", 1, 1, 1,1, 1,1, 0,0,0, 0,0, 0,1, 0,16'hAAAA, 0,16'h5555));
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(s[i]);
      @(negedge clk); e = exp_q.pop_front();
      checks++;
      if (stall !== e.stall) begin
        failures++; $display("FAIL %s stall got %b want %b", e.name, stall, e.stall);
      end
      checks++;
      if (stall_count !== exp_cnt || sat_count !== exp_sat) begin
        failures++;
        $display("FAIL %s count got %0d/%0d want %0d/%0d", e.name, stall_count, sat_count,
                 exp_cnt, exp_sat);
      end
      checks++;
      if (fwd_rs_sel !== e.rs_sel || fwd_rs_data !== e.rs_d ||
          fwd_rt_sel !== e.rt_sel || fwd_rt_data !== e.rt_d) begin
        failures++;
        $display("FAIL %s fwd got rs=%0d:%h rt=%0d:%h want rs=%0d:%h rt=%0d:%h", e.name,
                 fwd_rs_sel, fwd_rs_data, fwd_rt_sel, fwd_rt_data, e.rs_sel, e.rs_d,
                 e.rt_sel, e.rt_d);
      end
      advance(s[i]);
    end
  endtask

  task automatic test_saturate();
    step_t s[$];
    step_t e;
    set_data(16'h1234, 16'h2222, 16'h3333);
    for (int k = 0; k < 4; k++) begin
      s.push_back(mk("t6_load", 1, 1, 3,1, 0,0, 1,1,1, 0,0, 0,1, 0,16'hAAAA, 0,16'h5555));
      s.push_back(mk("t6_stall", 1, 1, 1,1, 0,0, 0,0,0, 0,0, 1,0, 0,16'h0, 0,16'h0));
    end
    s.push_back(mk("t6_end", 1, 0, 3,0, 3,0, 0,0,0, 0,0, 0,1, 0,16'hAAAA, 0,16'h5555));
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(s[i]);
      @(negedge clk); e = exp_q.pop_front();
      checks++;
      if (stall !== e.stall || sat_stall !== e.stall) begin
        failures++;
        $display("FAIL %s stall got %b/%b want %b", e.name, stall, sat_stall, e.stall);
      end
      checks++;
      if (stall_count !== exp_cnt || sat_count !== exp_sat) begin
        failures++;
        $display("FAIL %s count got %0d/%0d want %0d/%0d", e.name, stall_count, sat_count,
                 exp_cnt, exp_sat);
      end
      advance(s[i]);
    end
  endtask

  initial begin
    reset_n = 1'b0; freeze = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_rs = '0; id_rt = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    id_wr_en = 1'b0; id_wr_reg = '0; id_is_load = 1'b0;
    set_data(16'h1234, 16'h2222, 16'h3333);
    @(posedge clk); #1;
    test_reset();
    test_ex_forward();
    test_load_use();
    test_back_to_back();
    test_freeze();
    test_flush_reset();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
